pipe_stage_skid: RTL and testbench

Generic, parametrised pipeline-stage register for the core pipeline, replacing the fixed-field stall-only stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage gets a valid/ready handshake, a two-entry skid buffer so that `in_ready` never depends combinationally on `out_ready`, and a synchronous flush that turns the stage into a bubble. A saturating back-pressure counter is included for performance debug.

---
 rtl/pipe_stage_skid_if.sv | 13 +
 rtl/pipe_stage_skid.sv | 122 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready beat bus carrying ctrl and data payloads
interface pipe_stage_skid_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 7
);
  logic                  valid;
  logic                  ready;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with two-entry skid buffer, flush and stall counter
module pipe_stage_skid #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  accept;
  logic                  drain;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  load_skid;

  // Every output is decoded from registered state, so in_ready never sees out_ready.
  assign up.ready = (state != TWO);
  assign dn.valid = (state != EMPTY);
  assign dn.ctrl  = (state != EMPTY) ? main_ctrl : '0;
  assign dn.data  = main_data;

  assign accept = up.valid & (state != TWO);
  assign drain  = (state != EMPTY) & dn.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Flush clears only the ctrl bits; data registers keep their last contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= up.ctrl;
        main_data <= up.data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= up.ctrl;
        skid_data <= up.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if ((state != EMPTY) && !dn.ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid against a beat-queue model
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 7;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          cnt_clr;
  logic [NW-1:0] stall_cnt;

  pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) up_if ();
  pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dn_if ();

  pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt),
    .up        (up_if),
    .dn        (dn_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of at most two beats; the head is what the outputs show.
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         mq[$];
  logic [DW-1:0] m_last = '0;
  int            m_cnt  = 0;
  int            cyc    = 0;
  bit            m_drn;
  bit            m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
      cyc++;
      m_drn = (mq.size() > 0) && dn_if.ready;
      m_acc = up_if.valid && (mq.size() < 2);
      if (cnt_clr) m_cnt = 0;
      else if ((mq.size() > 0) && !dn_if.ready && (m_cnt < (1 << NW) - 1)) m_cnt++;
      if (m_drn) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (m_acc) mq.push_back('{c: up_if.ctrl, d: up_if.data});
      if (mq.size() > 0) m_last = mq[0].d;
    end
  end

  bit            logging = 1'b0;
  int            acc_log[$];
  int            out_log[$];
  logic [DW-1:0] dat_log[$];

  always @(negedge clk) begin
    check("cmp_valid", dn_if.valid, mq.size() > 0);
    check("cmp_ready", up_if.ready, mq.size() < 2);
    check("cmp_ctrl", dn_if.ctrl, (mq.size() > 0) ? mq[0].c : '0);
    check("cmp_data", dn_if.data, (mq.size() > 0) ? mq[0].d : m_last);
    check("cmp_stall", stall_cnt, m_cnt);
    if (logging) begin
      if (up_if.valid && up_if.ready) acc_log.push_back(cyc);
      if (dn_if.valid && dn_if.ready) begin
        out_log.push_back(cyc);
        dat_log.push_back(dn_if.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    up_if.valid = 1'b1;
    up_if.ctrl  = c;
    up_if.data  = d;
    tick();
    up_if.valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    flush       = 1'b0;
    cnt_clr     = 1'b0;
    up_if.valid = 1'b0;
    up_if.ctrl  = '0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", dn_if.valid, 0);
    check("rst_ctrl", dn_if.ctrl, 0);
    check("rst_data", dn_if.data, 0);
    check("rst_ready", up_if.ready, 1);
    check("rst_stall", stall_cnt, 0);
    rst = 1'b1;
    tick();

    // Streaming 1..8 back to back
    dn_if.ready = 1'b1;
    logging     = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_if.valid = 1'b1;
      up_if.ctrl  = 7'h55;
      up_if.data  = DW'(i);
      tick();
    end
    up_if.valid = 1'b0;
    repeat (3) tick();
    logging = 1'b0;
    check("stream_count", dat_log.size(), 8);
    if (dat_log.size() == 8 && acc_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("stream_data", dat_log[i], i + 1);
        check("stream_latency", out_log[i] - acc_log[i], 1);
        check("stream_gapless", out_log[i] - out_log[0], i);
      end
    end
    check("stream_stall", stall_cnt, 0);

    // Back-pressure: A, B held, then drained
    cnt_clr = 1'b1;
    tick();
    cnt_clr     = 1'b0;
    dn_if.ready = 1'b0;
    send(7'h11, 16'h0A0A);
    send(7'h22, 16'h0B0B);
    check("bp_ready_two", up_if.ready, 0);
    check("bp_valid", dn_if.valid, 1);
    check("bp_data_a", dn_if.data, 16'h0A0A);
    check("bp_ctrl_a", dn_if.ctrl, 7'h11);
    repeat (2) tick();
    check("bp_stall3", stall_cnt, 3);
    dn_if.ready = 1'b1;
    tick();
    check("bp_data_b", dn_if.data, 16'h0B0B);
    check("bp_ctrl_b", dn_if.ctrl, 7'h22);
    check("bp_ready_back", up_if.ready, 1);
    check("bp_stall_hold", stall_cnt, 3);
    tick();
    check("bp_empty_valid", dn_if.valid, 0);
    check("bp_empty_ctrl", dn_if.ctrl, 0);
    check("bp_empty_data", dn_if.data, 16'h0B0B);

    // Flush in TWO with C offered, together with cnt_clr
    dn_if.ready = 1'b0;
    send(7'h33, 16'h00C1);
    send(7'h44, 16'h00C2);
    up_if.valid = 1'b1;
    up_if.ctrl  = 7'h7F;
    up_if.data  = 16'h00CC;
    flush       = 1'b1;
    cnt_clr     = 1'b1;
    tick();
    flush       = 1'b0;
    cnt_clr     = 1'b0;
    up_if.valid = 1'b0;
    check("fl_valid", dn_if.valid, 0);
    check("fl_ctrl", dn_if.ctrl, 0);
    check("fl_data", dn_if.data, 16'h00C1);
    check("fl_stall", stall_cnt, 0);
    check("fl_ready", up_if.ready, 1);
    dn_if.ready = 1'b1;
    repeat (3) tick();
    check("fl_no_c", dn_if.valid, 0);
    up_if.valid = 1'b1;
    up_if.ctrl  = 7'h01;
    up_if.data  = 16'h00DD;
    flush       = 1'b1;
    tick();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    check("fl_discard", dn_if.valid, 0);

    // Counter saturation
    dn_if.ready = 1'b0;
    send(7'h05, 16'h005A);
    repeat (20) tick();
    check("sat_stall", stall_cnt, 4'hF);
    check("sat_valid", dn_if.valid, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_clr", stall_cnt, 0);
    tick();
    check("sat_restart", stall_cnt, 1);

    // Asynchronous reset while in TWO
    send(7'h06, 16'h0077);
    check("rst2_two", up_if.ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("rst2_valid", dn_if.valid, 0);
    check("rst2_ctrl", dn_if.ctrl, 0);
    check("rst2_data", dn_if.data, 0);
    check("rst2_ready", up_if.ready, 1);
    check("rst2_stall", stall_cnt, 0);
    #2;
    rst = 1'b1;
    tick();
    check("rst2_after", dn_if.valid, 0);

    // Random valid/ready traffic with occasional flush and clear
    for (int i = 0; i < 10000; i++) begin
      up_if.valid = ($urandom_range(0, 3) != 0);
      up_if.ctrl  = CW'($urandom_range(1, 127));
      up_if.data  = DW'(i);
      dn_if.ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      cnt_clr     = ($urandom_range(0, 127) == 0);
      tick();
    end
    up_if.valid = 1'b0;
    flush       = 1'b0;
    cnt_clr     = 1'b0;
    dn_if.ready = 1'b1;
    repeat (4) tick();
    check("end_drained", dn_if.valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
